univ_shift_reg: RTL
===================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register: hold, shift right, shift left and
//  parallel load on one WIDTH-bit register, with serial I/O at both ends.
//  A frame counter flags each completed WIDTH-shift serialisation.
//  Shared SISO/SIPO/PISO/PIPO building block for the serial datapaths.
// PARAMETERS
//  WIDTH  8  register width in bits; legal range >= 2
//  CNT_W  $clog2(WIDTH+1)  frame-counter width; localparam, not overridable
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  clear_n    in   1      synchronous reset, active-low
//  en         in   1      clock enable; 0 = freeze all state
//  mode       in   2      00 hold, 01 shift right, 10 shift left, 11 load
//  si_r       in   1      serial in for shift right; enters q[WIDTH-1]
//  si_l       in   1      serial in for shift left; enters q[0]
//  pdata      in   WIDTH  parallel load data
//  q          out  WIDTH  register contents (registered)
//  so_r       out  1      right-shift serial out = q[0] (combinational from q)
//  so_l       out  1      left-shift serial out = q[WIDTH-1] (comb. from q)
//  shift_cnt  out  CNT_W  shifts completed in current frame, 0..WIDTH-1
//  frame_done out  1      one-cycle pulse (registered) after WIDTH-th shift
// BEHAVIOUR
//  - One clock, one synchronous active-low reset; no async paths.
//  - Priority per edge: clear_n=0 > en=0 > mode decode.
//  - Reset: q=0, shift_cnt=0, frame_done=0; so_r=so_l=0 as a result.
//  - en=0: q and shift_cnt hold; frame_done driven 0 that cycle.
//  - mode 00: q and shift_cnt hold; frame_done=0.
//  - mode 01: q <= {si_r, q[WIDTH-1:1]}; bit shifted out is prior q[0].
//  - mode 10: q <= {q[WIDTH-2:0], si_l}; bit shifted out is prior q[WIDTH-1].
//  - mode 11: q <= pdata; shift_cnt <= 0; frame_done=0. Load starts a frame.
//  - Latency: q reflects input one edge after sampling; so_r/so_l valid same
//    cycle as q. No combinational path from inputs to any output.
//  - Frame count, on each shift (mode 01 or 10 with en=1):
//      shift_cnt != WIDTH-1: shift_cnt++, frame_done <= 0.
//      shift_cnt == WIDTH-1: shift_cnt <= 0 (wrap), frame_done <= 1.
//  - frame_done is high exactly one cycle per wrap; back-to-back frames of
//    continuous shifting give one pulse every WIDTH shifting cycles.
//  - Direction change mid-frame: count continues, not restarted.
//  - Hold or en=0 mid-frame: count frozen, frame resumes on next shift.
//  - Load on the cycle a frame would complete: load wins, no pulse, cnt=0.
//  - clear_n=0 mid-frame: all state to reset values regardless of en/mode;
//    a pending frame_done is dropped.
//  - Unlisted mode values do not exist (2-bit full decode); X on mode is a
//    bench error, not a design case.
// TESTING (WIDTH=4 unless stated)
//  T1 reset: clear_n=0 with en=1, mode=11, pdata=F for 2 edges -> q=0,
//     shift_cnt=0, frame_done=0, so_r=so_l=0.
//  T2 PISO right: load pdata=4'b1011, then 4 right shifts si_r=0 -> so_r
//     sequence 1,1,0,1 (LSB first); q=0 after; frame_done high the
//     cycle after the 4th shift edge only; shift_cnt 1,2,3,0.
//  T3 SIPO left: after reset, shift left with si_l=1,0,0,1 -> q=4'b1001,
//     frame_done pulse once; continue 4 more shifts -> second pulse exactly
//     4 cycles later.
//  T4 stall/mix: load 4'b0110, shift right, hold 2 cycles, en=0 1 cycle,
//     shift left, shift left -> shift_cnt 1,1,1,1,2,3, no pulse; q tracked
//     against bit-accurate model each cycle.
//  T5 collisions: 3 shifts then load 4'hA on 4th cycle -> q=A, cnt=0, no
//     pulse; 3 shifts then clear_n=0 -> all zero, no pulse.
//  T6 WIDTH=2 and WIDTH=16: random mode/en/si/pdata, 2000 cycles, q,
//     so_*, shift_cnt, frame_done match reference model every cycle.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load
// on one WIDTH-bit register. A frame counter flags every WIDTH-th shift.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   clear_n    synchronous reset, active-low (highest priority)
//   en         clock enable; 0 freezes q/shift_cnt, frame_done goes low
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   si_r       serial in for shift right (enters q[WIDTH-1])
//   si_l       serial in for shift left (enters q[0])
//   pdata      parallel load data
//   q          register contents (registered)
//   so_r       right-shift serial out, q[0] (combinational from q)
//   so_l       left-shift serial out, q[WIDTH-1] (combinational from q)
//   shift_cnt  shifts completed in the current frame, 0..WIDTH-1 (registered)
//   frame_done one-cycle pulse after the WIDTH-th shift of a frame (registered)
module univ_shift_reg #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("univ_shift_reg: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;

  // Next-state: data path and frame counter
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        MODE_HOLD: ;
        MODE_SHR: begin
          q_d   = {si_r, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_SHL: begin
          q_d   = {q_q[WIDTH-2:0], si_l};
          shift = 1'b1;
        end
        MODE_LOAD: begin
          // A load always starts a fresh frame, even on a would-be wrap
          q_d   = pdata;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Direction does not matter to the counter; it only counts shifts
    if (shift) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q          = q_q;
  assign so_r       = q_q[0];
  assign so_l       = q_q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule
